fc_dense_cu: RTL

// - Control unit for the fully-connected stage directly downstream of the last conv stage.
// - Consumes the IN_FEATURES-deep 1x1 output maps from the conv stage's ping-pong buffer.
// - Per output neuron: drives feature/weight/bias read addresses, the MAC enable and the accumulator clear.
// - Then writes the ReLU'd result and hands the frame to the next stage.

---
 rtl/fc_dense_cu_if.sv | 61 ++++++
 rtl/fc_dense_cu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fc_dense_cu_if.sv
// Bus between the fully-connected control unit and its feature/weight/bias
// memories, MAC datapath, output bank and neighbouring pipeline stages.
// Optional feature: define ARGMAX_EN to add class_index / class_valid.
interface fc_dense_cu_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned IN_FEATURES  = 160,
    parameter int unsigned OUT_FEATURES = 10
);
    localparam int unsigned IFM_AW = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
    localparam int unsigned WM_AW  = (IN_FEATURES * OUT_FEATURES > 1) ?
                                     $clog2(IN_FEATURES * OUT_FEATURES) : 1;
    localparam int unsigned BM_AW  = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1;

    logic                  start_from_previous;
    logic                  end_to_previous;
    logic                  end_from_next;
    logic                  start_to_next;
    logic                  ifm_sel;
    logic                  ifm_enable_read;
    logic [IFM_AW-1:0]     ifm_address_read;
    logic                  wm_enable_read;
    logic [WM_AW-1:0]      wm_address_read;
    logic                  bm_enable_read;
    logic [BM_AW-1:0]      bm_address_read;
    logic                  mac_enable;
    logic                  acc_clear;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  out_write;
    logic [BM_AW-1:0]      out_address;
    logic [DATA_WIDTH-1:0] out_data;
`ifdef ARGMAX_EN
    logic [BM_AW-1:0]      class_index;
    logic                  class_valid;
`endif

    modport master (
        input  start_from_previous, end_from_next, acc_data,
        output end_to_previous, start_to_next, ifm_sel,
        output ifm_enable_read, ifm_address_read,
        output wm_enable_read, wm_address_read,
        output bm_enable_read, bm_address_read,
        output mac_enable, acc_clear,
        output out_write, out_address, out_data
`ifdef ARGMAX_EN
        , output class_index, class_valid
`endif
    );

    modport slave (
        output start_from_previous, end_from_next, acc_data,
        input  end_to_previous, start_to_next, ifm_sel,
        input  ifm_enable_read, ifm_address_read,
        input  wm_enable_read, wm_address_read,
        input  bm_enable_read, bm_address_read,
        input  mac_enable, acc_clear,
        input  out_write, out_address, out_data
`ifdef ARGMAX_EN
        , input class_index, class_valid
`endif
    );
endinterface

// File: rtl/fc_dense_cu.sv
// Control unit for the fully-connected stage after the last conv stage.
// Sequences feature/weight/bias reads per output neuron, waits out the MAC
// pipeline, writes the ReLU'd result and hands the frame downstream.
// Optional feature: define ARGMAX_EN to track the winning class per frame.
module fc_dense_cu #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned IN_FEATURES  = 160,
    parameter int unsigned OUT_FEATURES = 10,
    parameter int unsigned MAC_LATENCY  = 3
) (
    input  logic          clk,
    input  logic          reset,
    fc_dense_cu_if.master bus
);
    localparam int unsigned IFM_AW  = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
    localparam int unsigned WM_AW   = (IN_FEATURES * OUT_FEATURES > 1) ?
                                      $clog2(IN_FEATURES * OUT_FEATURES) : 1;
    localparam int unsigned BM_AW   = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1;
    localparam int unsigned DRAIN_W = (MAC_LATENCY > 0) ? $clog2(MAC_LATENCY + 1) : 1;

    localparam logic [IFM_AW-1:0]  LAST_I    = IFM_AW'(IN_FEATURES - 1);
    localparam logic [BM_AW-1:0]   LAST_N    = BM_AW'(OUT_FEATURES - 1);
    localparam logic [DRAIN_W-1:0] LAST_D    = DRAIN_W'(MAC_LATENCY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        DRAIN     = 3'd2,
        WRITE     = 3'd3,
        WAIT_NEXT = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IFM_AW-1:0]   feat_idx;
    logic [WM_AW-1:0]    weight_addr;
    logic [BM_AW-1:0]    neuron_idx;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                bank_sel;
    logic                mac_enable_q;
    logic                acc_clear_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.start_from_previous) state_next = READ;
            READ:      if (feat_idx == LAST_I)      state_next = DRAIN;
            DRAIN:     if (drain_cnt == LAST_D)     state_next = WRITE;
            WRITE:     state_next = (neuron_idx == LAST_N) ? WAIT_NEXT : READ;
            WAIT_NEXT: if (bus.end_from_next)       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output decode from state and counters
    always_comb begin
        bus.end_to_previous  = 1'b0;
        bus.start_to_next    = 1'b0;
        bus.ifm_enable_read  = 1'b0;
        bus.wm_enable_read   = 1'b0;
        bus.bm_enable_read   = 1'b0;
        bus.out_write        = 1'b0;
        case (state)
            IDLE:      bus.end_to_previous = 1'b1;
            READ: begin
                bus.ifm_enable_read = 1'b1;
                bus.wm_enable_read  = 1'b1;
                bus.bm_enable_read  = 1'b1;
            end
            WRITE:     bus.out_write     = 1'b1;
            WAIT_NEXT: bus.start_to_next = bus.end_from_next;
            default:   ;
        endcase
    end

    assign bus.ifm_sel          = bank_sel;
    assign bus.ifm_address_read = feat_idx;
    assign bus.wm_address_read  = weight_addr;
    assign bus.bm_address_read  = neuron_idx;
    assign bus.out_address      = neuron_idx;
    assign bus.mac_enable       = mac_enable_q;
    assign bus.acc_clear        = acc_clear_q;
    assign bus.out_data         = bus.acc_data[DATA_WIDTH-1] ? '0 : bus.acc_data;

    // Feature, weight, neuron and drain counters plus input bank select
    always_ff @(posedge clk) begin
        if (reset) begin
            feat_idx    <= '0;
            weight_addr <= '0;
            neuron_idx  <= '0;
            drain_cnt   <= '0;
            bank_sel    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_from_previous) begin
                    bank_sel    <= ~bank_sel;
                    feat_idx    <= '0;
                    weight_addr <= '0;
                    neuron_idx  <= '0;
                    drain_cnt   <= '0;
                end
                READ: begin
                    weight_addr <= weight_addr + WM_AW'(1);
                    drain_cnt   <= '0;
                    feat_idx    <= (feat_idx == LAST_I) ? '0 : feat_idx + IFM_AW'(1);
                end
                DRAIN: drain_cnt <= drain_cnt + DRAIN_W'(1);
                WRITE: neuron_idx <= (neuron_idx == LAST_N) ? '0 : neuron_idx + BM_AW'(1);
                default: ;
            endcase
        end
    end

    // MAC enable trails the read enable by the memory read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            mac_enable_q <= 1'b0;
            acc_clear_q  <= 1'b0;
        end else begin
            mac_enable_q <= (state == READ);
            acc_clear_q  <= (state == READ) && (feat_idx == '0);
        end
    end

`ifdef ARGMAX_EN
    logic [DATA_WIDTH-1:0] best_val;
    logic [BM_AW-1:0]      best_idx;
    logic [BM_AW-1:0]      class_idx_q;
    logic                  take_c;
    logic                  last_write_c;
    logic [BM_AW-1:0]      win_idx_c;

    // Running winner including the neuron being written; strict > keeps lowest index on ties
    always_comb begin
        last_write_c = (state == WRITE) && (neuron_idx == LAST_N);
        take_c       = (neuron_idx == '0) || ($signed(bus.out_data) > $signed(best_val));
        win_idx_c    = take_c ? neuron_idx : best_idx;
    end

    // Best-so-far tracking and per-frame class latch
    always_ff @(posedge clk) begin
        if (reset) begin
            best_val    <= '0;
            best_idx    <= '0;
            class_idx_q <= '0;
        end else if (state == WRITE) begin
            if (take_c) begin
                best_val <= bus.out_data;
                best_idx <= neuron_idx;
            end
            if (last_write_c) class_idx_q <= win_idx_c;
        end
    end

    assign bus.class_valid = last_write_c;
    assign bus.class_index = last_write_c ? win_idx_c : class_idx_q;
`endif
endmodule
